// File: rtl/bcd_time_counter.sv
// hh:mm:ss packed-BCD clock/timer with a 1 s prescaler, run/stop, clear and preset load.
// Feeds the six digit nibbles of the seven-segment scan driver; all outputs registered.
module bcd_time_counter #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic       dir,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    input  logic [7:0] set_hour,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] hour0,
    output logic [3:0] hour1,
    output logic       running,
    output logic       tick,
    output logic       expired,
    output logic       load_err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    state_t        state_q, state_d;
    logic [23:0]   time_q, time_d;      // {hour, min, sec}, ones nibble lowest
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          tick_q, tick_d;
    logic          load_err_q, load_err_d;

    logic [23:0] nxt_up, nxt_dn;
    logic        load_ok, time_zero, wrap;

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [5:0][3:0] d;
        d = t;
        if (d[0] != 4'd9) d[0] = d[0] + 4'd1;
        else begin
            d[0] = 4'd0;
            if (d[1] != 4'd5) d[1] = d[1] + 4'd1;
            else begin
                d[1] = 4'd0;
                if (d[2] != 4'd9) d[2] = d[2] + 4'd1;
                else begin
                    d[2] = 4'd0;
                    if (d[3] != 4'd5) d[3] = d[3] + 4'd1;
                    else begin
                        d[3] = 4'd0;
                        if (d[5] == 4'd2 && d[4] == 4'd3) begin
                            d[5] = 4'd0;
                            d[4] = 4'd0;
                        end else if (d[4] == 4'd9) begin
                            d[4] = 4'd0;
                            d[5] = d[5] + 4'd1;
                        end else d[4] = d[4] + 4'd1;
                    end
                end
            end
        end
        return d;
    endfunction

    // Never called with 00:00:00; that case expires without a decrement.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [5:0][3:0] d;
        d = t;
        if (d[0] != 4'd0) d[0] = d[0] - 4'd1;
        else begin
            d[0] = 4'd9;
            if (d[1] != 4'd0) d[1] = d[1] - 4'd1;
            else begin
                d[1] = 4'd5;
                if (d[2] != 4'd0) d[2] = d[2] - 4'd1;
                else begin
                    d[2] = 4'd9;
                    if (d[3] != 4'd0) d[3] = d[3] - 4'd1;
                    else begin
                        d[3] = 4'd5;
                        if (d[4] != 4'd0) d[4] = d[4] - 4'd1;
                        else if (d[5] != 4'd0) begin
                            d[4] = 4'd9;
                            d[5] = d[5] - 4'd1;
                        end else begin
                            d[5] = 4'd2;
                            d[4] = 4'd3;
                        end
                    end
                end
            end
        end
        return d;
    endfunction

    assign nxt_up    = bcd_inc(time_q);
    assign nxt_dn    = bcd_dec(time_q);
    assign time_zero = (time_q == 24'h0);
    assign wrap      = (presc_q == PRESC_MAX);
    assign load_ok   = (set_sec[7:4] <= 4'd5) && (set_sec[3:0] <= 4'd9) &&
                       (set_min[7:4] <= 4'd5) && (set_min[3:0] <= 4'd9) &&
                       (set_hour[3:0] <= 4'd9) &&
                       ((set_hour[7:4] < 4'd2) || (set_hour[7:4] == 4'd2 && set_hour[3:0] <= 4'd3));

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            time_d  = '0;
            presc_d = '0;
            state_d = IDLE;
        end else if (load) begin
            if (state_q != RUN && load_ok) begin
                time_d  = {set_hour, set_min, set_sec};
                presc_d = '0;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (start_stop) begin
            // Stopping keeps the prescaler, so a resume finishes the partial second.
            if (state_q == IDLE && !(dir && time_zero)) state_d = RUN;
            else if (state_q == RUN)                    state_d = IDLE;
        end else if (state_q == RUN) begin
            if (wrap) begin
                presc_d = '0;
                if (dir && time_zero) begin
                    state_d = EXPIRED;
                end else begin
                    time_d = dir ? nxt_dn : nxt_up;
                    tick_d = 1'b1;
                    if (dir && nxt_dn == 24'h0) state_d = EXPIRED;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            time_q     <= '0;
            presc_q    <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            tick_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            tick_q     <= tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign {hour1, hour0, min1, min0, sec1, sec0} = time_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign tick     = tick_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter at TICK_DIV=4: directed commands, tick-driven scoreboard of
// expected hh:mm:ss values computed from plain seconds arithmetic.
module tb_bcd_time_counter;
    logic       clk = 1'b0;
    logic       rst, start_stop, clear, load, dir;
    logic [7:0] set_sec, set_min, set_hour;
    logic [3:0] sec0, sec1, min0, min1, hour0, hour1;
    logic       running, tick, expired, load_err;

    int n_chk = 0;
    int n_err = 0;
    int tick_cnt = 0;
    int t0;
    logic [23:0] exp_q[$];
    logic [23:0] t_now;

    bcd_time_counter #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .load(load), .dir(dir),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
        .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1), .hour0(hour0), .hour1(hour1),
        .running(running), .tick(tick), .expired(expired), .load_err(load_err)
    );

    always #5 clk = ~clk;
    assign t_now = {hour1, hour0, min1, min0, sec1, sec0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    // Each tick pops the next expected time.
    always @(posedge clk) begin
        #2;
        if (tick) begin
            tick_cnt++;
            if (exp_q.size() == 0) chk("spurious_tick", {8'h0, t_now}, 32'hFFFFFFFF);
            else                   chk("tick_value", {8'h0, t_now}, {8'h0, exp_q.pop_front()});
        end
    end

    task automatic pulse_ss();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hour = h; set_min = m; set_sec = s;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start_stop = 1'b1; clear = 1'b0; load = 1'b1; dir = 1'b0;
        set_hour = 8'h12; set_min = 8'h34; set_sec = 8'h56;
        repeat (2) @(negedge clk);
        chk("rst_time", {8'h0, t_now}, 32'h0);
        chk("rst_flags", {running, tick, expired, load_err}, 4'b0000);
        rst = 1'b1; start_stop = 1'b0; load = 1'b0;
        @(negedge clk);

        // Up-count: 10 ticks, exactly one every 4 cycles
        for (int i = 1; i <= 10; i++) exp_q.push_back(to_bcd(i));
        t0 = tick_cnt;
        pulse_ss();
        chk("run_on", running, 1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            chk("tick_phase", tick, (i % 4 == 0));
        end
        chk("up_time", {8'h0, t_now}, {8'h0, to_bcd(10)});
        chk("up_running", running, 1);
        chk("up_ticks", tick_cnt - t0, 10);
        pulse_ss();
        chk("stop", running, 0);

        // Stop after 2 cycles, resume finishes the partial second
        do_clear();
        chk("clear_time", {8'h0, t_now}, 32'h0);
        pulse_ss();
        repeat (2) @(negedge clk);
        pulse_ss();
        chk("paused", running, 0);
        repeat (10) @(negedge clk);
        chk("paused_time", {8'h0, t_now}, 32'h0);
        exp_q.push_back(to_bcd(1));
        pulse_ss();
        chk("resumed", running, 1);
        @(negedge clk);
        chk("resume_tick1", tick, 0);
        @(negedge clk);
        chk("resume_tick2", tick, 1);
        pulse_ss();

        // Carry chain and day wrap
        do_clear();
        do_load(8'h23, 8'h59, 8'h58);
        chk("load_time", {8'h0, t_now}, {8'h0, to_bcd(86398)});
        chk("load_no_tick", tick, 0);
        exp_q.push_back(to_bcd(86399));
        exp_q.push_back(to_bcd(0));
        t0 = tick_cnt;
        pulse_ss();
        repeat (8) @(negedge clk);
        chk("wrap_time", {8'h0, t_now}, 32'h0);
        chk("wrap_running", running, 1);
        chk("wrap_ticks", tick_cnt - t0, 2);
        pulse_ss();

        // Load rejection, reset mid-run, clear+load, clear in RUN
        do_clear();
        do_load(8'h00, 8'h60, 8'h00);
        chk("bad_load_err", load_err, 1);
        chk("bad_load_time", {8'h0, t_now}, 32'h0);
        @(negedge clk);
        chk("bad_load_pulse", load_err, 0);
        do_load(8'h24, 8'h00, 8'h00);
        chk("bad_hour_err", load_err, 1);
        do_load(8'h05, 8'h43, 8'h21);
        chk("good_load", {8'h0, t_now}, 32'h054321);
        chk("good_load_err", load_err, 0);
        pulse_ss();
        do_load(8'h12, 8'h00, 8'h00);
        chk("run_load_err", load_err, 1);
        chk("run_load_time", {8'h0, t_now}, 32'h054321);
        chk("run_load_running", running, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_time", {8'h0, t_now}, 32'h0);
        chk("midrst_flags", {running, tick, expired, load_err}, 4'b0000);
        do_load(8'h01, 8'h02, 8'h03);
        set_hour = 8'h12; set_min = 8'h34; set_sec = 8'h56;
        clear = 1'b1; load = 1'b1;
        @(negedge clk);
        clear = 1'b0; load = 1'b0;
        chk("clr_load_time", {8'h0, t_now}, 32'h0);
        chk("clr_load_err", load_err, 0);
        do_load(8'h01, 8'h02, 8'h03);
        pulse_ss();
        @(negedge clk);
        do_clear();
        chk("run_clear_time", {8'h0, t_now}, 32'h0);
        chk("run_clear_running", running, 0);

        // Count-down: start ignored at zero, then 00:01:01 expires after 61 ticks
        dir = 1'b1;
        pulse_ss();
        chk("zero_start_ignored", running, 0);
        do_load(8'h00, 8'h01, 8'h01);
        for (int i = 60; i >= 0; i--) exp_q.push_back(to_bcd(i));
        pulse_ss();
        repeat (243) @(negedge clk);
        chk("pre_expire", expired, 0);
        @(negedge clk);
        chk("expired", expired, 1);
        chk("exp_running", running, 0);
        chk("exp_time", {8'h0, t_now}, 32'h0);
        repeat (6) @(negedge clk);
        pulse_ss();
        chk("exp_ss_ignored", {running, expired}, 2'b01);
        do_load(8'h00, 8'h00, 8'h05);
        chk("exp_load_time", {8'h0, t_now}, 32'h000005);
        chk("exp_load_state", {running, expired}, 2'b00);

        // Down-tick at 00:00:00 after a dir change: EXPIRED, no tick
        do_clear();
        dir = 1'b0;
        pulse_ss();
        dir = 1'b1;
        repeat (3) @(negedge clk);
        chk("zdown_pre", expired, 0);
        @(negedge clk);
        chk("zdown_expired", {running, expired, tick}, 3'b010);
        chk("zdown_time", {8'h0, t_now}, 32'h0);

        repeat (4) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
